uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 112 +++++++++++
 tb/tb_uart_rx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, 2-flop synced input, optional even parity via UART_RX_PARITY_EN
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       serialIn,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MID = 16'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  sh, sh_n, data_n;
  logic        pbad, pbad_n, valid_n, ferr_n, perr_n;
  logic        rx_meta, rx_s;
  logic        at_last;
  assign at_last = cnt == LAST;
  assign busy = state != IDLE;
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      pbad       <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_meta    <= serialIn;
      rx_s       <= rx_meta;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      pbad       <= pbad_n;
      data       <= data_n;
      valid      <= valid_n;
      frame_err  <= ferr_n;
      parity_err <= perr_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = at_last ? '0 : cnt + 16'd1;
    idx_n   = idx;
    sh_n    = sh;
    pbad_n  = pbad;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
          pbad_n  = 1'b0;
        end
      end
      START: begin
        if (cnt == MID) begin
          state_n = rx_s ? IDLE : DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (at_last) begin
          sh_n  = {rx_s, sh[7:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_last) begin
          pbad_n  = rx_s ^ (^sh);
          state_n = STOP;
        end
      end
      STOP: begin
        if (at_last) begin
          state_n = rx_s ? IDLE : BREAK;
          ferr_n  = !rx_s;
          valid_n = rx_s && !pbad;
          perr_n  = rx_s && pbad;
          data_n  = (rx_s && !pbad) ? sh : data;
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = CPB * NB;
  localparam int LAT = CPB * (NB - 1) + CPB / 2 + 3;
  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       serialIn = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;
  int cyc = 0;
  int vcyc = 0;
  int nvalid = 0;
  int nferr = 0;
  int nperr = 0;
  int npass = 0;
  int nchk = 0;
  int t0 = 0;
  int v1 = 0;
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk(sysclk),
    .reset(reset),
    .serialIn(serialIn),
    .data(data),
    .valid(valid),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .busy(busy)
  );
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) begin
    if (valid) begin
      nvalid = nvalid + 1;
      vcyc = cyc;
    end
    if (frame_err) nferr = nferr + 1;
    if (parity_err) nperr = nperr + 1;
    cyc = cyc + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask
  task automatic send(input logic [7:0] b, input logic par, input logic stop, input int hold);
    t0 = cyc;
    serialIn = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      repeat (CPB) @(negedge sysclk);
    end
    if (NB == 11) begin
      serialIn = par;
      repeat (CPB) @(negedge sysclk);
    end
    serialIn = stop;
    repeat (hold) @(negedge sysclk);
  endtask
  initial begin
    #200000;
    $error("FAIL timeout: observed running expected finished");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge sysclk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (5) @(negedge sysclk);
    send(8'h41, ^8'h41, 1'b1, CPB);
    chk("f41_cnt", nvalid, 1);
    chk("f41_data", data, 8'h41);
    chk("f41_lat", vcyc - t0, LAT);
    chk("f41_ferr", nferr, 0);
    chk("f41_busy", busy, 0);
    serialIn = 1'b0;
    repeat (5) @(negedge sysclk);
    serialIn = 1'b1;
    chk("glitch_busy_mid", busy, 1);
    repeat (20) @(negedge sysclk);
    chk("glitch_busy", busy, 0);
    chk("glitch_valid", nvalid, 1);
    chk("glitch_ferr", nferr, 0);
    chk("glitch_data", data, 8'h41);
    send(8'h55, ^8'h55, 1'b0, 40);
    chk("brk_busy", busy, 1);
    chk("brk_ferr", nferr, 1);
    chk("brk_valid", nvalid, 1);
    chk("brk_data", data, 8'h41);
    serialIn = 1'b1;
    repeat (CPB) @(negedge sysclk);
    chk("brk_idle", busy, 0);
    chk("brk_ferr_once", nferr, 1);
    send(8'hAA, ^8'hAA, 1'b1, CPB);
    chk("fAA_cnt", nvalid, 2);
    chk("fAA_data", data, 8'hAA);
    send(8'h55, ^8'h55, 1'b1, CPB);
    chk("b2b_data1", data, 8'h55);
    v1 = vcyc;
    send(8'hAA, ^8'hAA, 1'b1, CPB);
    chk("b2b_gap", vcyc - v1, FRAME);
    chk("b2b_cnt", nvalid, 4);
    chk("b2b_data2", data, 8'hAA);
    serialIn = 1'b0;
    repeat (CPB) @(negedge sysclk);
    serialIn = 1'b1;
    repeat (CPB) @(negedge sysclk);
    repeat (CPB / 2) @(negedge sysclk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    chk("mrst_data", data, 8'h00);
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_ferr", frame_err, 0);
    repeat (CPB * 2) @(negedge sysclk);
    chk("mrst_nopulse", nvalid + nferr + nperr, 5);
    send(8'h7E, ^8'h7E, 1'b1, CPB);
    chk("f7E_cnt", nvalid, 5);
    chk("f7E_data", data, 8'h7E);
`ifdef UART_RX_PARITY_EN
    send(8'h41, 1'b0, 1'b1, CPB);
    chk("par_ok_cnt", nvalid, 6);
    chk("par_ok_data", data, 8'h41);
    send(8'h41, 1'b1, 1'b1, CPB);
    chk("par_bad_perr", nperr, 1);
    chk("par_bad_valid", nvalid, 6);
    chk("par_bad_data", data, 8'h41);
`else
    chk("perr_never", nperr, 0);
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
